// File: rtl/gray_counter_ud_pkg.sv
// rtl/gray_counter_ud_pkg.sv - shared Gray-code helpers, direction encoding and step-select enum
package gray_counter_ud_pkg;

    localparam int GRAY_MAXW = 32;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_STEP = 2'd2,
        OP_SAT  = 2'd3
    } step_op_e;

    // Operands are zero-extended to GRAY_MAXW, so any WIDTH <= 32 slices back cleanly
    function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] gray);
        logic [GRAY_MAXW-1:0] bin;
        bin[GRAY_MAXW-1] = gray[GRAY_MAXW-1];
        for (int i = GRAY_MAXW - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_counter_ud_encode.sv
// rtl/gray_counter_ud_encode.sv - combinational binary to Gray encoder (module gray_encode)
module gray_encode
    import gray_counter_ud_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = WIDTH'(bin2gray(32'(bin_i)));

endmodule

// File: rtl/gray_counter_ud.sv
// rtl/gray_counter_ud.sv - up/down Gray counter with load and tc; GRAY_COUNTER_SAT_EN selects saturation
module gray_counter_ud
    import gray_counter_ud_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             at_end;
    step_op_e         op;

    assign at_end = (up_dn == DIR_UP) ? (&b_q) : (b_q == '0);

    always_comb begin
        op = OP_HOLD;
        if (load) begin
            op = OP_LOAD;
        end else if (en) begin
`ifdef GRAY_COUNTER_SAT_EN
            op = at_end ? OP_SAT : OP_STEP;
`else
            op = OP_STEP;
`endif
        end
    end

    always_comb begin
        b_d = b_q;
        case (op)
            OP_LOAD: b_d = load_val;
            OP_STEP: b_d = (up_dn == DIR_UP) ? (b_q + WIDTH'(1)) : (b_q - WIDTH'(1));
            default: b_d = b_q;
        endcase
    end

    // Gray image is derived from the next binary value so both registers move on the same edge
    gray_encode #(.WIDTH(WIDTH)) u_enc (
        .bin_i  (b_d),
        .gray_o (q_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q <= RST_VAL;
            q_q <= WIDTH'(bin2gray(32'(RST_VAL)));
        end else begin
            b_q <= b_d;
            q_q <= q_d;
        end
    end

    assign b  = b_q;
    assign q  = q_q;
    assign tc = rst_n & en & ~load & at_end;

endmodule

// File: tb/tb_gray_counter_ud.sv
// tb/tb_gray_counter_ud.sv - self-checking bench for gray_counter_ud (honours GRAY_COUNTER_SAT_EN)
module tb_gray_counter_ud;

    localparam int W    = 4;
    localparam int MAXV = 15;
`ifdef GRAY_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         up_dn = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] b, q, b2, q2;
    logic         tc, tc2;

    int n_cmp = 0;
    int n_err = 0;
    int m_b;
    bit have_prev = 1'b0;
    logic [W-1:0] prev_q;

    always #5 clk = ~clk;

    gray_counter_ud #(.WIDTH(W), .RST_VAL(4'd0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .b(b), .q(q), .tc(tc)
    );

    gray_counter_ud #(.WIDTH(W), .RST_VAL(4'd10)) dut10 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .b(b2), .q(q2), .tc(tc2)
    );

    function automatic int model_next(input int cur, input bit e, input bit u, input bit l, input int v);
        if (l) return v;
        if (!e) return cur;
        if (u) return (cur == MAXV) ? (SAT ? MAXV : 0) : cur + 1;
        return (cur == 0) ? (SAT ? 0 : MAXV) : cur - 1;
    endfunction

    function automatic bit model_tc(input int cur, input bit e, input bit u, input bit l);
        return e && !l && ((u && cur == MAXV) || (!u && cur == 0));
    endfunction

    function automatic logic [W-1:0] gray_of(input int v);
        logic [W-1:0] x;
        x = v[W-1:0];
        return x ^ (x >> 1);
    endfunction

    // Structural checker: Gray image always consistent, at most one bit moves on non-load edges
    always @(negedge rst_n) have_prev = 1'b0;

    always @(posedge clk) begin
        logic ld_s, rs_s;
        ld_s = load;
        rs_s = rst_n;
        #2;
        n_cmp++;
        if (q !== (b ^ (b >> 1))) begin
            n_err++;
            $display("FAIL gray_image b=%0d q=%b required %b", b, q, b ^ (b >> 1));
        end
        if (have_prev && rs_s && !ld_s) begin
            n_cmp++;
            if ($countones(q ^ prev_q) > 1) begin
                n_err++;
                $display("FAIL one_bit_step q %b -> %b changed %0d bits, required <=1",
                         prev_q, q, $countones(q ^ prev_q));
            end
        end
        prev_q = q;
        have_prev = rs_s;
    end

    task automatic set_in(input bit e, input bit u, input bit l, input int v);
        @(negedge clk);
        en = e; up_dn = u; load = l; load_val = v[W-1:0];
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int eb[3] = '{1, 2, 3};
        logic [3:0] eq[3] = '{4'b0001, 4'b0011, 4'b0010};
        en = 1'b1; up_dn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (b !== 4'd0 || q !== 4'b0000 || tc !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state b=%0d q=%b tc=%b required 0/0000/0", b, q, tc);
        end
        n_cmp++;
        if (b2 !== 4'd10 || q2 !== 4'b1111 || tc2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rstval10 b=%0d q=%b tc=%b required 10/1111/0", b2, q2, tc2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b0, 1'b1, 1'b1, 5);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (b !== 4'd0 || q !== 4'b0000 || tc !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midcount b=%0d q=%b tc=%b required 0/0000/0", b, q, tc);
        end
        n_cmp++;
        if (b2 !== 4'd10 || q2 !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_midcount_rstval10 b=%0d q=%b required 10/1111", b2, q2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (b !== eb[i][3:0] || q !== eq[i]) begin
                n_err++;
                $display("FAIL release_count[%0d] b=%0d q=%b required %0d/%b", i, b, q, eb[i], eq[i]);
            end
        end
    endtask

    task automatic test_up_wrap();
        int eb[3];
        logic [3:0] eq[3];
        bit et[3];
        eb = SAT ? '{14, 15, 15} : '{14, 15, 0};
        eq = SAT ? '{4'b1001, 4'b1000, 4'b1000} : '{4'b1001, 4'b1000, 4'b0000};
        et = SAT ? '{1'b0, 1'b1, 1'b1} : '{1'b0, 1'b1, 1'b0};
        set_in(1'b0, 1'b1, 1'b1, 14);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (b !== eb[i][3:0] || q !== eq[i] || tc !== et[i]) begin
                n_err++;
                $display("FAIL up_wrap[%0d] b=%0d q=%b tc=%b required %0d/%b/%b",
                         i, b, q, tc, eb[i], eq[i], et[i]);
            end
            tick();
            #4;
        end
    endtask

    task automatic test_down_wrap();
        int eb[3];
        logic [3:0] eq[3];
        bit et[3];
        eb = SAT ? '{1, 0, 0} : '{1, 0, 15};
        eq = SAT ? '{4'b0001, 4'b0000, 4'b0000} : '{4'b0001, 4'b0000, 4'b1000};
        et = SAT ? '{1'b0, 1'b1, 1'b1} : '{1'b0, 1'b1, 1'b0};
        set_in(1'b0, 1'b0, 1'b1, 1);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (b !== eb[i][3:0] || q !== eq[i] || tc !== et[i]) begin
                n_err++;
                $display("FAIL down_wrap[%0d] b=%0d q=%b tc=%b required %0d/%b/%b",
                         i, b, q, tc, eb[i], eq[i], et[i]);
            end
            tick();
            #4;
        end
    endtask

    task automatic test_load_priority();
        set_in(1'b1, 1'b1, 1'b1, 9);
        n_cmp++;
        if (tc !== 1'b0) begin
            n_err++;
            $display("FAIL load_tc tc=%b required 0", tc);
        end
        tick();
        n_cmp++;
        if (b !== 4'd9 || q !== 4'b1101) begin
            n_err++;
            $display("FAIL load_prio b=%0d q=%b required 9/1101", b, q);
        end
        set_in(1'b0, 1'b1, 1'b0, 3);
        repeat (2) tick();
        n_cmp++;
        if (b !== 4'd9 || q !== 4'b1101 || tc !== 1'b0) begin
            n_err++;
            $display("FAIL hold b=%0d q=%b tc=%b required 9/1101/0", b, q, tc);
        end
        set_in(1'b1, 1'b1, 1'b1, 15);
        tick();
        set_in(1'b1, 1'b1, 1'b1, 15);
        n_cmp++;
        if (tc !== 1'b0) begin
            n_err++;
            $display("FAIL load_same_tc tc=%b required 0", tc);
        end
        tick();
        n_cmp++;
        if (b !== 4'd15 || q !== 4'b1000) begin
            n_err++;
            $display("FAIL load_same b=%0d q=%b required 15/1000", b, q);
        end
    endtask

    task automatic test_direction_flip();
        int eb[4] = '{8, 7, 8, 7};
        logic [3:0] eq[4] = '{4'b1100, 4'b0100, 4'b1100, 4'b0100};
        set_in(1'b0, 1'b1, 1'b1, 7);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, (i % 2 == 0), 1'b0, 0);
            tick();
            n_cmp++;
            if (b !== eb[i][3:0] || q !== eq[i]) begin
                n_err++;
                $display("FAIL dir_flip[%0d] b=%0d q=%b required %0d/%b", i, b, q, eb[i], eq[i]);
            end
        end
    endtask

    task automatic test_random();
        int lv;
        bit e, u, l;
        lv = $urandom_range(0, MAXV);
        set_in(1'b0, 1'b0, 1'b1, lv);
        tick();
        m_b = lv;
        for (int i = 0; i < 400; i++) begin
            e = $urandom_range(0, 3) != 0;
            u = $urandom_range(0, 1);
            l = $urandom_range(0, 9) == 0;
            lv = (m_b < MAXV && $urandom_range(0, 1)) ? m_b : $urandom_range(0, MAXV);
            set_in(e, u, l, lv);
            n_cmp++;
            if (tc !== model_tc(m_b, e, u, l)) begin
                n_err++;
                $display("FAIL rand_tc[%0d] tc=%b required %b (b=%0d)", i, tc, model_tc(m_b, e, u, l), m_b);
            end
            tick();
            m_b = model_next(m_b, e, u, l, lv);
            n_cmp++;
            if (b !== m_b[W-1:0] || q !== gray_of(m_b)) begin
                n_err++;
                $display("FAIL rand_state[%0d] b=%0d q=%b required %0d/%b", i, b, q, m_b, gray_of(m_b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_direction_flip();
        test_random();
        set_in(1'b0, 1'b0, 1'b0, 0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
